// File: rtl/matrix_loader.sv
// ----------------------------------------------------------------------------
// matrix_loader
//
// Purpose:
//   Collects a stream of element words into two packed matrices, A then B,
//   each MATRIX_N x MATRIX_M elements of WIDTH bits, stored row-major. Once
//   both are complete it presents them (read_ready) until the downstream
//   multiplier signals completion with a rising edge on compute_done. It then
//   starts collecting the next pair.
//
// Optional feature:
//   MATRIX_LOADER_CHECKSUM_EN - when defined, a modulo-2^WIDTH sum of all
//   A and B words is kept. One extra word is accepted after B and compared
//   with the sum. A match presents the matrices. A mismatch pulses load_err
//   for one cycle and restarts the load. When undefined there is no CHECK
//   state and load_err is tied low.
//
// Handshake:
//   A word transfers on a rising clk edge where s_valid and s_ready are both
//   1. s_valid may rise or fall at any time and never depends on s_ready.
//   s_ready is 1 in every load state (FILL_A, FILL_B, CHECK) and 0 in
//   PRESENT and while reset is high.
//
// Ports:
//   clk          in   single clock, all state on its rising edge
//   reset        in   asynchronous active-high reset
//   s_valid      in   upstream word valid
//   s_ready      out  loader accepts a word this cycle
//   s_data       in   upstream element word (WIDTH)
//   abort        in   synchronous discard of the partial load
//   compute_done in   level status from the multiplier
//   read_ready   out  matrix_a/matrix_b complete and stable
//   matrix_a     out  packed matrix A, element e at [e*WIDTH +: WIDTH]
//   matrix_b     out  packed matrix B, same layout
//   load_err     out  one-cycle pulse on checksum mismatch
//   dbg_state_o  out  current FSM state (debug/observability)
//   dbg_index_o  out  current word index within the matrix being filled
// ----------------------------------------------------------------------------
module matrix_loader #(
    parameter int MATRIX_N = 3,
    parameter int MATRIX_M = 3,
    parameter int WIDTH    = 16,
    localparam int NUM_EL  = MATRIX_N * MATRIX_M,
    localparam int IDX_W   = (NUM_EL > 1) ? $clog2(NUM_EL) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_data,
    input  logic                      abort,
    input  logic                      compute_done,
    output logic                      read_ready,
    output logic [NUM_EL*WIDTH-1:0]   matrix_a,
    output logic [NUM_EL*WIDTH-1:0]   matrix_b,
    output logic                      load_err,
    output logic [1:0]                dbg_state_o,
    output logic [IDX_W-1:0]          dbg_index_o
);

    localparam logic [1:0] S_FILL_A  = 2'd0;
    localparam logic [1:0] S_FILL_B  = 2'd1;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHECK   = 2'd2;
`endif
    localparam logic [1:0] S_PRESENT = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    ready_en_q;
    logic                    cd_q;
    logic [NUM_EL*WIDTH-1:0] mat_a_q;
    logic [NUM_EL*WIDTH-1:0] mat_b_q;

    logic accept;
    logic last_el;
    logic cd_rise;
    logic wr_a;
    logic wr_b;

    assign accept  = s_valid && s_ready;
    assign last_el = (idx_q == IDX_W'(NUM_EL - 1));
    // Only a genuine 0->1 transition releases PRESENT; a level that was
    // already high when PRESENT was entered has no edge and is ignored.
    assign cd_rise = compute_done && !cd_q;

    // ready_en_q holds s_ready low during reset and lets it rise on the
    // first clock edge after reset is released.
    assign s_ready    = ready_en_q && (state_q != S_PRESENT);
    assign read_ready = (state_q == S_PRESENT);

    // abort wins over a word accepted in the same cycle: that word is dropped.
    assign wr_a = accept && !abort && (state_q == S_FILL_A);
    assign wr_b = accept && !abort && (state_q == S_FILL_B);

    assign matrix_a    = mat_a_q;
    assign matrix_b    = mat_b_q;
    assign dbg_state_o = state_q;
    assign dbg_index_o = idx_q;

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             err_q, err_d;

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = 1'b0;
`endif
        if (abort) begin
            state_d = S_FILL_A;
            idx_d   = '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            case (state_q)
                S_FILL_A: begin
                    if (accept) begin
                        idx_d = last_el ? '0 : idx_q + IDX_W'(1);
`ifdef MATRIX_LOADER_CHECKSUM_EN
                        sum_d = sum_q + s_data;
`endif
                        if (last_el) begin
                            state_d = S_FILL_B;
                        end
                    end
                end
                S_FILL_B: begin
                    if (accept) begin
                        idx_d = last_el ? '0 : idx_q + IDX_W'(1);
`ifdef MATRIX_LOADER_CHECKSUM_EN
                        sum_d = sum_q + s_data;
                        if (last_el) begin
                            state_d = S_CHECK;
                        end
`else
                        if (last_el) begin
                            state_d = S_PRESENT;
                        end
`endif
                    end
                end
`ifdef MATRIX_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        if (s_data == sum_q) begin
                            state_d = S_PRESENT;
                        end else begin
                            state_d = S_FILL_A;
                            err_d   = 1'b1;
                            sum_d   = '0;
                        end
                    end
                end
`endif
                S_PRESENT: begin
                    if (cd_rise) begin
                        state_d = S_FILL_A;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                default: begin
                    state_d = S_FILL_A;
                    idx_d   = '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FILL_A;
            idx_q      <= '0;
            ready_en_q <= 1'b0;
            cd_q       <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_en_q <= 1'b1;
            cd_q       <= compute_done;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    // Matrix storage: contents persist across loads and are overwritten one
    // element at a time, so a partial or aborted load leaves older data in
    // the untouched elements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else begin
            if (wr_a) begin
                mat_a_q[idx_q*WIDTH +: WIDTH] <= s_data;
            end
            if (wr_b) begin
                mat_b_q[idx_q*WIDTH +: WIDTH] <= s_data;
            end
        end
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter MATRIX_N, default 3, matrix rows.
REQ-002 SHALL have parameter MATRIX_M, default 3, matrix columns.
REQ-003 SHALL have parameter WIDTH, default 16, element width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  upstream word valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port s_data  input  WIDTH  upstream element word.
REQ-009 SHALL have port abort  input  1  synchronous discard of the partial load.
REQ-010 SHALL have port compute_done  input  1  level status from the multiplier.
REQ-011 SHALL have port read_ready  output  1  matrix_a/matrix_b complete and stable.
REQ-012 SHALL have port matrix_a  output  MATRIX_N*MATRIX_M*WIDTH  packed matrix A.
REQ-013 SHALL have port matrix_b  output  MATRIX_N*MATRIX_M*WIDTH  packed matrix B.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse on checksum mismatch (zero when macro absent).

Function
REQ-015 SHALL implement states FILL_A, FILL_B, CHECK, PRESENT; CHECK exists only with MATRIX_LOADER_CHECKSUM_EN.
REQ-016 SHALL accept a word only when s_valid and s_ready are both 1; s_ready SHALL be 1 in FILL_A, FILL_B and CHECK, else 0.
REQ-017 SHALL store element e = row*MATRIX_M + col at bits [e*WIDTH +: WIDTH]; words arrive row-major, A then B.
REQ-018 SHALL keep a word index counter 0..MATRIX_N*MATRIX_M-1 that wraps to 0 on the last element of each matrix.
REQ-019 SHALL move FILL_A->FILL_B on the accepted last A element; FILL_B->PRESENT (or CHECK) on the accepted last B element.
REQ-020 SHALL assert read_ready in PRESENT only, starting the cycle after the last accepted word (or checksum word).
REQ-021 SHALL hold matrix_a and matrix_b unchanged while read_ready is 1.
REQ-022 SHALL register compute_done each cycle and detect its 0->1 rising edge; the registered copy resets to 0.
REQ-023 SHALL leave PRESENT for FILL_A on a rising edge of compute_done, deasserting read_ready the next cycle; a compute_done held high on entry SHALL NOT release PRESENT.
REQ-024 SHALL, on abort=1 in any state, go to FILL_A and clear the index; abort SHALL win over a simultaneous accepted word, which is discarded.
REQ-025 SHALL leave matrix_a/matrix_b contents from a previous load in place until overwritten element-by-element.

Reset
REQ-026 SHALL on reset asynchronously enter FILL_A with index 0, read_ready 0, s_ready 0 while reset is high, load_err 0, and matrix_a/matrix_b all zero.
REQ-027 SHALL assert s_ready on the first clock edge after reset deasserts.

Configuration
REQ-028 SHALL, with MATRIX_LOADER_CHECKSUM_EN defined, accumulate a WIDTH-bit modulo-2^WIDTH sum of all accepted A and B words and accept one extra word in CHECK.
REQ-029 SHALL, with the macro defined, go CHECK->PRESENT when the extra word equals the sum, else pulse load_err one cycle and go to FILL_A; the sum clears on entering FILL_A.
REQ-030 SHALL, without the macro, omit CHECK and the accumulator, going FILL_B->PRESENT directly, with load_err tied 0.

Verification
REQ-031 Reset, then stream 1..9 then 10..18 with s_valid held 1 -> matrix_a element 0 = 1, element 8 = 9, matrix_b element 0 = 10, element 8 = 18; read_ready 1 the cycle after word 18.
REQ-032 Stream with s_valid toggling every other cycle -> same packed result; exactly 18 words accepted.
REQ-033 compute_done held 1 before PRESENT -> read_ready stays 1; drop to 0 then raise -> read_ready 0 one cycle after the rising edge, s_ready 1.
REQ-034 abort asserted after 5 A words together with a valid word -> index 0, state FILL_A, next word lands in matrix_a element 0.
REQ-035 With MATRIX_LOADER_CHECKSUM_EN, words 1..18 then 171 -> read_ready 1; words 1..18 then 170 -> load_err pulses once, read_ready stays 0.
REQ-036 Reset asserted mid-FILL_B -> outputs zero immediately, independent of clk.
